pipe_hazard_ctrl: RTL and testbench

Pipeline hazard scheduler for the five-stage core. It shadows the destination-register state of the EX, MEM and WB stages in a three-entry scoreboard. From that state it drives the operand-forwarding selects for the ID/EX operands, stalls IF/ID on load-use hazards and inserts bubbles into ID/EX. It sits beside the decode stage and is the only source of pipeline-hold and forward controls.

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard scheduler for the five-stage core. Shadows the
//               destination-register state of EX, MEM and WB in a three-entry
//               scoreboard. Produces operand-forwarding selects for ID/EX,
//               holds PC/IF-ID on load-use hazards and inserts ID/EX bubbles.
// Ports       :
//   clk          in   pipeline clock, rising edge
//   clrn         in   asynchronous active-low reset
//   IDvalid      in   ID stage holds a real instruction
//   IDrs/IDrt    in   ID source register numbers (5 bits each)
//   IDuse_rs/rt  in   ID instruction actually reads rs / rt
//   IDwreg       in   ID instruction writes the register file
//   IDm2reg      in   ID instruction is a load
//   IDwn         in   ID destination register number
//   flush        in   kill the ID instruction this cycle
//   stall        out  hold PC and IF/ID this cycle
//   pc_we        out  PC write enable (~stall)
//   ifid_we      out  IF/ID write enable (~stall)
//   idex_bubble  out  ID/EX loads a NOP (stall | flush)
//   fwda/fwdb    out  forward selects: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt    out  saturating count of stall cycles since reset
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        IDvalid,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic        IDuse_rs,
    input  logic        IDuse_rt,
    input  logic        IDwreg,
    input  logic        IDm2reg,
    input  logic [4:0]  IDwn,
    input  logic        flush,
    output logic        stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_bubble,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0]  c_FWD_RF  = 2'b00;
    localparam logic [1:0]  c_FWD_EX  = 2'b01;
    localparam logic [1:0]  c_FWD_MEM = 2'b10;
    localparam logic [1:0]  c_FWD_WB  = 2'b11;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Scoreboard entries {v, wreg, m2reg, wn} for EX, MEM and WB
    logic        r_ex_v,    r_mem_v,    r_wb_v;
    logic        r_ex_wreg, r_mem_wreg, r_wb_wreg;
    logic        r_ex_m2reg, r_mem_m2reg, r_wb_m2reg;
    logic [4:0]  r_ex_wn,   r_mem_wn,   r_wb_wn;
    logic [15:0] r_stall_cnt;

    logic        w_ex_rs, w_mem_rs, w_wb_rs;
    logic        w_ex_rt, w_mem_rt, w_wb_rt;
    logic        w_stall;
    logic [1:0]  w_fwda, w_fwdb;

    // A stage produces a usable value for r only if it holds a live writer of
    // r; register 0 is hard-wired so it never participates.
    function automatic logic f_match(input logic v, input logic wreg,
                                     input logic [4:0] wn, input logic [4:0] r);
        return v & wreg & (wn == r) & (r != 5'd0);
    endfunction

    assign w_ex_rs  = f_match(r_ex_v,  r_ex_wreg,  r_ex_wn,  IDrs);
    assign w_mem_rs = f_match(r_mem_v, r_mem_wreg, r_mem_wn, IDrs);
    assign w_wb_rs  = f_match(r_wb_v,  r_wb_wreg,  r_wb_wn,  IDrs);
    assign w_ex_rt  = f_match(r_ex_v,  r_ex_wreg,  r_ex_wn,  IDrt);
    assign w_mem_rt = f_match(r_mem_v, r_mem_wreg, r_mem_wn, IDrt);
    assign w_wb_rt  = f_match(r_wb_v,  r_wb_wreg,  r_wb_wn,  IDrt);

    // Only a load still in EX is a hazard: its data is not ready until MEM,
    // where the datapath selects load data vs ALU result by its own m2reg.
    // A flushed instruction is discarded, so it never stalls.
    assign w_stall = IDvalid & ~flush & r_ex_m2reg &
                     ((IDuse_rs & w_ex_rs) | (IDuse_rt & w_ex_rt));

    // Youngest producer wins: EX, then MEM, then WB.
    always_comb begin
        w_fwda = c_FWD_RF;
        if (IDuse_rs) begin
            if (w_ex_rs)       w_fwda = c_FWD_EX;
            else if (w_mem_rs) w_fwda = c_FWD_MEM;
            else if (w_wb_rs)  w_fwda = c_FWD_WB;
        end
    end

    always_comb begin
        w_fwdb = c_FWD_RF;
        if (IDuse_rt) begin
            if (w_ex_rt)       w_fwdb = c_FWD_EX;
            else if (w_mem_rt) w_fwdb = c_FWD_MEM;
            else if (w_wb_rt)  w_fwdb = c_FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ex_v      <= 1'b0;
            r_ex_wreg   <= 1'b0;
            r_ex_m2reg  <= 1'b0;
            r_ex_wn     <= 5'd0;
            r_mem_v     <= 1'b0;
            r_mem_wreg  <= 1'b0;
            r_mem_m2reg <= 1'b0;
            r_mem_wn    <= 5'd0;
            r_wb_v      <= 1'b0;
            r_wb_wreg   <= 1'b0;
            r_wb_m2reg  <= 1'b0;
            r_wb_wn     <= 5'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_wb_v      <= r_mem_v;
            r_wb_wreg   <= r_mem_wreg;
            r_wb_m2reg  <= r_mem_m2reg;
            r_wb_wn     <= r_mem_wn;
            r_mem_v     <= r_ex_v;
            r_mem_wreg  <= r_ex_wreg;
            r_mem_m2reg <= r_ex_m2reg;
            r_mem_wn    <= r_ex_wn;
            // A stalled or flushed instruction becomes a bubble (v=0); the
            // other fields are carried but never matched because v gates them.
            r_ex_v      <= IDvalid & ~w_stall & ~flush;
            r_ex_wreg   <= IDwreg;
            r_ex_m2reg  <= IDm2reg;
            r_ex_wn     <= IDwn;
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stall       = w_stall;
    assign pc_we       = ~w_stall;
    assign ifid_we     = ~w_stall;
    assign idex_bubble = w_stall | flush;
    assign fwda        = w_fwda;
    assign fwdb        = w_fwdb;
    assign stall_cnt   = r_stall_cnt;

    // WB m2reg is shadowed for completeness but nothing downstream needs it.
    logic w_unused;
    assign w_unused = r_wb_m2reg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl. Inputs are
//               applied 1 ns after the rising edge and outputs are sampled
//               2 ns later, well away from either clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        IDvalid, IDuse_rs, IDuse_rt, IDwreg, IDm2reg, flush;
    logic [4:0]  IDrs, IDrt, IDwn;
    logic        stall, pc_we, ifid_we, idex_bubble;
    logic [1:0]  fwda, fwdb;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .clrn(clrn),
        .IDvalid(IDvalid), .IDrs(IDrs), .IDrt(IDrt),
        .IDuse_rs(IDuse_rs), .IDuse_rt(IDuse_rt),
        .IDwreg(IDwreg), .IDm2reg(IDm2reg), .IDwn(IDwn), .flush(flush),
        .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_bubble(idex_bubble), .fwda(fwda), .fwdb(fwdb),
        .stall_cnt(stall_cnt)
    );

    // Present one ID-stage instruction for the next cycle.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic ld, input logic [4:0] wn, input logic fl);
        @(posedge clk);
        #1;
        IDvalid = v; IDrs = rs; IDrt = rt; IDuse_rs = urs; IDuse_rt = urt;
        IDwreg = wr; IDm2reg = ld; IDwn = wn; flush = fl;
        #2;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        IDvalid = 0; IDrs = 0; IDrt = 0; IDuse_rs = 0; IDuse_rt = 0;
        IDwreg = 0; IDm2reg = 0; IDwn = 0; flush = 0;
        #2;
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", stall_cnt); end
        total++; if ({stall, pc_we, ifid_we, idex_bubble} !== 4'b0110) begin bad++; $display("FAIL reset_ctl: got %b want 0110", {stall, pc_we, ifid_we, idex_bubble}); end
        total++; if ({fwda, fwdb} !== 4'b0000) begin bad++; $display("FAIL reset_fwd: got %b want 0000", {fwda, fwdb}); end
        @(posedge clk); #4; clrn = 1'b1;
    endtask

    task automatic test_alu_fwd;
        nops(3);
        drive(1, 1, 2, 1, 1, 1, 0, 3, 0);             // add r3,r1,r2
        total++; if ({fwda, fwdb, stall} !== 5'b00000) begin bad++; $display("FAIL alu_first: got %b want 00000", {fwda, fwdb, stall}); end
        drive(1, 3, 3, 1, 1, 1, 0, 4, 0);             // sub r4,r3,r3
        total++; if ({fwda, fwdb, stall} !== 5'b01010) begin bad++; $display("FAIL alu_ex: got %b want 01010", {fwda, fwdb, stall}); end
        drive(1, 1, 2, 1, 1, 1, 0, 8, 0);             // independent
        total++; if ({fwda, fwdb} !== 4'b0000) begin bad++; $display("FAIL alu_indep: got %b want 0000", {fwda, fwdb}); end
        drive(1, 3, 9, 1, 1, 0, 0, 0, 0);             // reads r3 from WB
        total++; if ({fwda, fwdb} !== 4'b1100) begin bad++; $display("FAIL alu_wb: got %b want 1100", {fwda, fwdb}); end
    endtask

    task automatic test_load_use;
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 1, 5, 0);             // ld r5,(r1)
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_issue: got %b want 0", stall); end
        drive(1, 5, 1, 1, 1, 1, 0, 6, 0);             // add r6,r5,r1
        total++; if ({stall, pc_we, ifid_we, idex_bubble} !== 4'b1001) begin bad++; $display("FAIL lu_stall: got %b want 1001", {stall, pc_we, ifid_we, idex_bubble}); end
        total++; if ({fwda, fwdb} !== 4'b0100) begin bad++; $display("FAIL lu_stall_fwd: got %b want 0100", {fwda, fwdb}); end
        drive(1, 5, 1, 1, 1, 1, 0, 6, 0);             // same add, re-presented
        total++; if ({stall, pc_we, idex_bubble, fwda} !== 5'b01010) begin bad++; $display("FAIL lu_release: got %b want 01010", {stall, pc_we, idex_bubble, fwda}); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %h want 0001", stall_cnt); end
    endtask

    task automatic test_back_to_back;
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 1, 10, 0);            // ld r10,(r1)
        drive(1, 10, 0, 1, 0, 1, 1, 11, 0);           // ld r11,(r10)
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall1: got %b want 1", stall); end
        drive(1, 10, 0, 1, 0, 1, 1, 11, 0);
        total++; if ({stall, fwda} !== 3'b010) begin bad++; $display("FAIL b2b_rel1: got %b want 010", {stall, fwda}); end
        drive(1, 1, 11, 1, 1, 1, 0, 12, 0);           // add r12,r1,r11
        total++; if ({stall, fwdb} !== 3'b101) begin bad++; $display("FAIL b2b_stall2: got %b want 101", {stall, fwdb}); end
        drive(1, 1, 11, 1, 1, 1, 0, 12, 0);
        total++; if ({stall, fwdb} !== 3'b010) begin bad++; $display("FAIL b2b_rel2: got %b want 010", {stall, fwdb}); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL b2b_cnt: got %h want 0003", stall_cnt); end
    endtask

    task automatic test_priority;
        nops(3);
        drive(1, 1, 2, 1, 1, 1, 0, 7, 0);             // add r7
        drive(1, 1, 2, 1, 1, 1, 0, 7, 0);             // add r7
        drive(1, 7, 0, 1, 0, 0, 0, 0, 0);             // read r7: EX beats MEM
        total++; if (fwda !== 2'b01) begin bad++; $display("FAIL prio_ex: got %b want 01", fwda); end
        drive(1, 0, 7, 0, 1, 0, 0, 0, 0);             // MEM beats WB
        total++; if (fwdb !== 2'b10) begin bad++; $display("FAIL prio_mem: got %b want 10", fwdb); end
        drive(1, 7, 7, 0, 1, 0, 0, 0, 0);             // rs not used; rt from WB
        total++; if ({fwda, fwdb} !== 4'b0011) begin bad++; $display("FAIL prio_use: got %b want 0011", {fwda, fwdb}); end
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 1, 0, 0);             // ld r0
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0);             // add r0,r0,r0
        total++; if ({fwda, fwdb, stall} !== 5'b00000) begin bad++; $display("FAIL r0: got %b want 00000", {fwda, fwdb, stall}); end
    endtask

    task automatic test_flush;
        nops(3);
        drive(1, 1, 0, 1, 0, 1, 1, 2, 0);             // ld r2
        drive(1, 2, 0, 1, 0, 1, 0, 13, 1);            // reader of r2, flushed
        total++; if ({stall, pc_we, idex_bubble} !== 3'b011) begin bad++; $display("FAIL flush_ctl: got %b want 011", {stall, pc_we, idex_bubble}); end
        drive(1, 13, 2, 1, 1, 0, 0, 0, 0);            // flushed r13 must be gone
        total++; if ({stall, fwda, fwdb} !== 5'b00010) begin bad++; $display("FAIL flush_bubble: got %b want 00010", {stall, fwda, fwdb}); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL flush_cnt: got %h want 0003", stall_cnt); end
    endtask

    // One load followed by a dependent reader: exactly one stall cycle.
    task automatic one_stall;
        drive(1, 1, 0, 1, 0, 1, 1, 5, 0);
        drive(1, 5, 0, 1, 0, 1, 0, 6, 0);
        drive(1, 5, 0, 1, 0, 1, 0, 6, 0);
    endtask

    task automatic test_reset_mid_stall;
        one_stall();
        one_stall();
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL mid_pre_cnt: got %h want 0005", stall_cnt); end
        drive(1, 1, 0, 1, 0, 1, 1, 5, 0);
        drive(1, 5, 5, 1, 1, 1, 0, 6, 0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_stall: got %b want 1", stall); end
        #1 clrn = 1'b0;
        #1;
        total++; if ({stall_cnt, stall, fwda, fwdb} !== 21'd0) begin bad++; $display("FAIL mid_reset: got cnt=%h st=%b a=%b b=%b want all 0", stall_cnt, stall, fwda, fwdb); end
        IDvalid = 0; IDuse_rs = 0; IDuse_rt = 0; IDwreg = 0; IDm2reg = 0;
        @(posedge clk); #4; clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            total++; if ({stall_cnt, stall, idex_bubble, fwda, fwdb} !== 22'd0) begin bad++; $display("FAIL post_reset%0d: got cnt=%h st=%b bub=%b", i, stall_cnt, stall, idex_bubble); end
        end
    endtask

    // The counter is preloaded near its ceiling so saturation is reached in a
    // handful of cycles instead of 65536 stalls.
    task automatic test_saturation;
        @(posedge clk); #4;
        force dut.r_stall_cnt = 16'hFFFD;
        #1;
        release dut.r_stall_cnt;
        #1;
        total++; if (stall_cnt !== 16'hFFFD) begin bad++; $display("FAIL sat_preload: got %h want fffd", stall_cnt); end
        one_stall();
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt); end
        one_stall();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt); end
        one_stall();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        one_stall();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold2: got %h want ffff", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_back_to_back();
        test_priority();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
